// File: rtl/compressor_scan_harness_pkg.sv
// Shared types and sizing helpers for the compressor scan harness.
package compressor_harness_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    EVAL,
    CAPT,
    UNLOAD
  } state_t;

  // Wide enough to hold the largest per-state cycle count without wrapping.
  function automatic int cnt_width(input int width, input int n_dst, input int eval_cyc);
    int m;
    m = width;
    if (n_dst > m) m = n_dst;
    if (eval_cyc > m) m = eval_cyc;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/compressor_scan_harness_if.sv
// Pad-side bundle of the scan harness: operand scan-in, core buses, result scan-out.
interface compressor_scan_harness_if #(
  parameter int N_CH  = 31,
  parameter int WIDTH = 31,
  parameter int N_DST = 37
);
  logic                  start;
  logic [N_CH-1:0]       sin;
  logic [N_CH*WIDTH-1:0] src_bus;
  logic [N_DST-1:0]      dst_bus;
  logic                  sout;
  logic                  sout_valid;
  logic                  busy;
  logic                  done;

  modport master (
    output start, sin, dst_bus,
    input  src_bus, sout, sout_valid, busy, done
  );

  modport slave (
    input  start, sin, dst_bus,
    output src_bus, sout, sout_valid, busy, done
  );
endinterface

// File: rtl/compressor_scan_harness_sreg_chan.sv
// One operand channel: MSB-first serial shift register with synchronous clear.
module sreg_chan #(
  parameter int WIDTH = 31
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             shift_en,
  input  logic             sin,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_d;

  generate
    if (WIDTH > 1) begin : g_wide
      assign q_d = {q[WIDTH-2:0], sin};
    end else begin : g_one
      assign q_d = sin;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (shift_en) begin
      q <= q_d;
    end
  end

endmodule

// File: rtl/compressor_scan_harness.sv
// Scan harness top: loads operands serially, lets the core settle, captures
// its result and shifts it out LSB-first with start/busy/done handshake.
module compressor_scan_harness
  import compressor_harness_pkg::*;
#(
  parameter int N_CH     = 31,
  parameter int WIDTH    = 31,
  parameter int N_DST    = 37,
  parameter int EVAL_CYC = 1
) (
  input logic clk,
  input logic rst,
  compressor_scan_harness_if.slave bus
);

  localparam int CW = cnt_width(WIDTH, N_DST, EVAL_CYC);
  localparam logic [CW-1:0] LOAD_LAST   = CW'(WIDTH - 1);
  localparam logic [CW-1:0] EVAL_LAST   = CW'(EVAL_CYC - 1);
  localparam logic [CW-1:0] UNLOAD_LAST = CW'(N_DST - 1);

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [N_DST-1:0]    cap_q, cap_d;
  logic                done_q, done_d;
  logic                shift_en;
  logic [N_CH-1:0]     sin_w;
  logic [N_CH*WIDTH-1:0] src_flat;

  assign shift_en = (state_q == LOAD);
  assign sin_w    = bus.sin;

  // Operand registers only move during LOAD, so the core inputs stay
  // stable through EVAL, unload, done and IDLE.
  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_chan
      sreg_chan #(.WIDTH(WIDTH)) u_chan (
        .clk     (clk),
        .rst     (rst),
        .shift_en(shift_en),
        .sin     (sin_w[gi]),
        .q       (src_flat[gi*WIDTH +: WIDTH])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cap_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cap_q   <= cap_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cap_d   = cap_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = LOAD;
          cnt_d   = '0;
        end
      end
      LOAD: begin
        if (cnt_q == LOAD_LAST) begin
          state_d = EVAL;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      EVAL: begin
        if (cnt_q == EVAL_LAST) begin
          state_d = CAPT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      CAPT: begin
        cap_d   = bus.dst_bus;
        state_d = UNLOAD;
        cnt_d   = '0;
      end
      UNLOAD: begin
        cap_d = cap_q >> 1;
        if (cnt_q == UNLOAD_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    bus.src_bus    = src_flat;
    bus.busy       = (state_q != IDLE);
    bus.sout_valid = (state_q == UNLOAD);
    bus.sout       = (state_q == UNLOAD) ? cap_q[0] : 1'b0;
    bus.done       = done_q;
  end

endmodule

// File: tb/tb_compressor_scan_harness.sv
// Scoreboard bench: stimulus queues expected result bits and done cycles,
// per-DUT monitors pop and compare whenever the harness presents output.
module tb_compressor_scan_harness;

  localparam int NA = 31, WA = 31, DA = 37, EA = 1;
  localparam int NB = 4,  WB = 8,  DB = 12, EB = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct {
    int   cyc;
    logic b;
  } sbit_t;

  sbit_t qa_bits[$];
  sbit_t qb_bits[$];
  int    qa_done[$];
  int    qb_done[$];

  compressor_scan_harness_if #(.N_CH(NA), .WIDTH(WA), .N_DST(DA)) if_a ();
  compressor_scan_harness_if #(.N_CH(NB), .WIDTH(WB), .N_DST(DB)) if_b ();

  compressor_scan_harness #(.N_CH(NA), .WIDTH(WA), .N_DST(DA), .EVAL_CYC(EA)) dut_a (
    .clk(clk),
    .rst(rst),
    .bus(if_a.slave)
  );

  compressor_scan_harness #(.N_CH(NB), .WIDTH(WB), .N_DST(DB), .EVAL_CYC(EB)) dut_b (
    .clk(clk),
    .rst(rst),
    .bus(if_b.slave)
  );

  // Core model for the small harness: an adder of the four operands.
  always_comb begin
    if_b.dst_bus = '0;
    for (int c = 0; c < NB; c++) if_b.dst_bus = if_b.dst_bus + DB'(if_b.src_bus[c*WB +: WB]);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_src(input string name, input logic [NA*WA-1:0] act, input logic [NA*WA-1:0] exp);
    int bad;
    bad = -1;
    tests_run++;
    for (int c = NA - 1; c >= 0; c--) if (act[c*WA +: WA] !== exp[c*WA +: WA]) bad = c;
    if (bad >= 0) begin
      tests_failed++;
      $display("FAIL %s: channel %0d got %h expected %h", name, bad, act[bad*WA +: WA], exp[bad*WA +: WA]);
    end
  endtask

  task automatic fail_now(input string name);
    tests_run++;
    tests_failed++;
    $display("FAIL %s: got unexpected output expected none (cycle %0d)", name, cyc);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) step();
  endtask

  // Drives one default-harness transaction starting in the current cycle.
  task automatic load_a(input logic [NA*WA-1:0] ops, input logic [DA-1:0] dst,
                        input int pulse_at, input int abort_at, output int t0);
    sbit_t e;
    t0 = cyc;
    if_a.dst_bus = dst;
    if (abort_at < 0) begin
      for (int i = 0; i < DA; i++) begin
        e.cyc = t0 + WA + EA + 2 + i;
        e.b   = dst[i];
        qa_bits.push_back(e);
      end
      qa_done.push_back(t0 + WA + EA + DA + 2);
    end
    if_a.start = 1'b1;
    step();
    if_a.start = 1'b0;
    for (int i = 1; i <= WA; i++) begin
      for (int c = 0; c < NA; c++) if_a.sin[c] = ops[c*WA + (WA - i)];
      if_a.start = (i == pulse_at);
      if (i == abort_at) begin
        rst = 1'b1;
        step();
        rst = 1'b0;
        if_a.sin = '0;
        if_a.start = 1'b0;
        return;
      end
      if (i == 5) check("a_busy_in_load", if_a.busy, 1);
      step();
    end
    if_a.sin = '0;
    if_a.start = 1'b0;
  endtask

  task automatic load_b(input logic [NB*WB-1:0] ops, output int t0);
    sbit_t e;
    logic [DB-1:0] sum;
    t0 = cyc;
    sum = '0;
    for (int c = 0; c < NB; c++) sum = sum + DB'(ops[c*WB +: WB]);
    for (int i = 0; i < DB; i++) begin
      e.cyc = t0 + WB + EB + 2 + i;
      e.b   = sum[i];
      qb_bits.push_back(e);
    end
    qb_done.push_back(t0 + WB + EB + DB + 2);
    if_b.start = 1'b1;
    step();
    if_b.start = 1'b0;
    for (int i = 1; i <= WB; i++) begin
      for (int c = 0; c < NB; c++) if_b.sin[c] = ops[c*WB + (WB - i)];
      step();
    end
    if_b.sin = '0;
  endtask

  always @(negedge clk) begin
    sbit_t e;
    int    d;
    if (if_a.sout_valid === 1'b1) begin
      if (qa_bits.size() == 0) fail_now("a_unexpected_sout_valid");
      else begin
        e = qa_bits.pop_front();
        check("a_sout_cycle", cyc, e.cyc);
        check("a_sout_bit", if_a.sout, e.b);
      end
    end else begin
      check("a_sout_idle_zero", {if_a.sout, if_a.sout_valid}, 0);
    end
    if (if_a.done === 1'b1) begin
      if (qa_done.size() == 0) fail_now("a_unexpected_done");
      else begin
        d = qa_done.pop_front();
        check("a_done_cycle", cyc, d);
      end
    end
  end

  always @(negedge clk) begin
    sbit_t e;
    int    d;
    if (if_b.sout_valid === 1'b1) begin
      if (qb_bits.size() == 0) fail_now("b_unexpected_sout_valid");
      else begin
        e = qb_bits.pop_front();
        check("b_sout_cycle", cyc, e.cyc);
        check("b_sout_bit", if_b.sout, e.b);
      end
    end
    if (if_b.done === 1'b1) begin
      if (qb_done.size() == 0) fail_now("b_unexpected_done");
      else begin
        d = qb_done.pop_front();
        check("b_done_cycle", cyc, d);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NA*WA-1:0] ops, ops2;
    logic [NB*WB-1:0] ops_b;
    int t0, t1;

    if_a.start = 1'b0; if_a.sin = '0; if_a.dst_bus = '0;
    if_b.start = 1'b0; if_b.sin = '0;

    // Test 1: reset with garbage on the inputs.
    rst = 1'b1;
    if_a.start = 1'b1;
    if_a.sin = NA'($urandom);
    if_a.dst_bus = DA'({$urandom, $urandom});
    if_b.start = 1'b1;
    step();
    step();
    check_src("rst_src_a", if_a.src_bus, '0);
    check("rst_outs_a", {if_a.sout, if_a.sout_valid, if_a.busy, if_a.done}, 0);
    check("rst_outs_b", {if_b.src_bus, if_b.sout, if_b.sout_valid, if_b.busy, if_b.done}, 0);
    rst = 1'b0;
    if_a.start = 1'b0; if_a.sin = '0; if_b.start = 1'b0;
    step();
    check("idle_after_rst", if_a.busy, 0);

    // Test 2: single bit on channel 0, known result pattern.
    ops = '0;
    ops[WA-1] = 1'b1;
    load_a(ops, 37'h10_0000_0001, -1, -1, t0);
    check_src("t2_src_after_load", if_a.src_bus, ops);
    wait_until(t0 + 71);
    check("t2_done_at_71", if_a.done, 1);
    check_src("t2_src_hold_at_done", if_a.src_bus, ops);
    step();
    check("t2_done_one_pulse", if_a.done, 0);
    step();

    // Test 3: stray starts while busy are ignored.
    for (int c = 0; c < NA; c++) ops[c*WA +: WA] = WA'(32'h1234_5677 * (c + 1));
    load_a(ops, 37'h1F_0F0F_1234, 10, -1, t0);
    check_src("t3_src_after_load", if_a.src_bus, ops);
    wait_until(t0 + 40);
    if_a.start = 1'b1;
    step();
    if_a.start = 1'b0;
    wait_until(t0 + 72);
    check("t3_idle_after_done", if_a.busy, 0);
    step();

    // Test 4: reset mid-LOAD aborts, then a fresh start completes.
    load_a(ops, 37'h0A_5A5A_5A5A, -1, 15, t0);
    check_src("t4_src_cleared", if_a.src_bus, '0);
    check("t4_idle_after_abort", if_a.busy, 0);
    wait_until(t0 + 20);
    ops2 = ops ^ {NA*WA{1'b1}};
    load_a(ops2, 37'h0A_5A5A_5A5A, -1, -1, t1);
    check_src("t4_src_restart", if_a.src_bus, ops2);
    wait_until(t0 + 92);

    // Test 6: back-to-back transactions, second start in the done cycle.
    for (int c = 0; c < NA; c++) ops[c*WA +: WA] = WA'(32'h0101_0101 * c + 3);
    for (int c = 0; c < NA; c++) ops2[c*WA +: WA] = WA'(32'h7654_3210 ^ (c << 7));
    load_a(ops, 37'h15_A5C3_0F81, -1, -1, t0);
    check_src("t6_first_src", if_a.src_bus, ops);
    wait_until(t0 + 71);
    check("t6_done_first", if_a.done, 1);
    load_a(ops2, 37'h02_3C3C_E001, -1, -1, t1);
    check("t6_second_started", t1, t0 + 71);
    check_src("t6_second_src", if_a.src_bus, ops2);
    wait_until(t1 + 72);

    // Test 5: small harness with an adder core, random operands.
    for (int k = 0; k < 3; k++) begin
      ops_b = $urandom;
      load_b(ops_b, t0);
      check("t5_src_b", if_b.src_bus, ops_b);
      wait_until(t0 + 26);
    end

    repeat (4) step();
    check("qa_bits_drained", qa_bits.size(), 0);
    check("qa_done_drained", qa_done.size(), 0);
    check("qb_bits_drained", qb_bits.size(), 0);
    check("qb_done_drained", qb_done.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
